// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/video memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] ROM_REGION    = 2'b00;
    localparam int         VID_BURST_DEF = 3;

endpackage

// File: rtl/strobe_edge.sv
// CPU strobe history, rising-edge detect and pending-request tracking.
module strobe_edge (
    input  logic clock,
    input  logic reset,
    input  logic cpu_rd,
    input  logic cpu_wr,
    input  logic cpu_grant,
    output logic cpu_pend
);

    logic stb;
    logic rise;
    logic stb_q;
    logic arm_q;
    logic pend_q, pend_d;

    assign stb  = cpu_rd | cpu_wr;
    // arm_q stays low until the strobe has been seen low, so a strobe
    // already high when reset releases never looks like an edge.
    assign rise = stb & ~stb_q & arm_q;

    // Dropping both strobes before the grant cancels the request.
    assign cpu_pend = (pend_q | rise) & stb;
    assign pend_d   = cpu_pend & ~cpu_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            stb_q  <= 1'b0;
            arm_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            stb_q  <= stb;
            pend_q <= pend_d;
            if (!stb)
                arm_q <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between a CPU and a video reader (3-cycle accesses).
// Optional macro ROM_PROTECT_EN blocks CPU writes to the ROM region.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int VID_BURST = VID_BURST_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_done,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wren,
    input  logic [7:0]  mem_q
);

    localparam int             SW        = $clog2(VID_BURST + 1);
    localparam logic [SW-1:0]  BURST_MAX = SW'(VID_BURST);

    state_t        state_q, state_d;
    logic          own_cpu_q, own_cpu_d;
    logic          rd_q, rd_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          mem_wren_q, mem_wren_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [7:0]    vid_rdata_q, vid_rdata_d;
    logic          cpu_done_q, cpu_done_d;
    logic          vid_ack_q, vid_ack_d;
    logic [SW-1:0] streak_q, streak_d;

    logic cpu_pend;
    logic cpu_grant;
    logic vid_grant;
    logic rom_hit;

`ifdef ROM_PROTECT_EN
    assign rom_hit = (cpu_addr[15:14] == ROM_REGION);
`else
    assign rom_hit = 1'b0;
`endif

    strobe_edge u_strobe (
        .clock     (clock),
        .reset     (reset),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_grant (cpu_grant),
        .cpu_pend  (cpu_pend)
    );

    always_comb begin
        state_d     = state_q;
        own_cpu_d   = own_cpu_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = mem_wren_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_done_d  = 1'b0;
        vid_ack_d   = 1'b0;
        cpu_grant   = 1'b0;
        vid_grant   = 1'b0;

        case (state_q)
            IDLE: begin
                // Video has priority until it has won VID_BURST times in a row
                // over a waiting CPU.
                if (cpu_pend && (!vid_req || streak_q == BURST_MAX))
                    cpu_grant = 1'b1;
                else if (vid_req)
                    vid_grant = 1'b1;

                if (cpu_grant) begin
                    own_cpu_d   = 1'b1;
                    rd_d        = cpu_rd;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    mem_wren_d  = ~cpu_rd & ~rom_hit;
                    state_d     = ISSUE;
                end else if (vid_grant) begin
                    own_cpu_d   = 1'b0;
                    rd_d        = 1'b1;
                    mem_addr_d  = vid_addr;
                    mem_wren_d  = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                mem_wren_d = 1'b0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (own_cpu_q) begin
                    cpu_done_d = 1'b1;
                    if (rd_q)
                        cpu_rdata_d = mem_q;
                end else begin
                    vid_ack_d   = 1'b1;
                    vid_rdata_d = mem_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        if (!cpu_pend || cpu_grant)
            streak_d = '0;
        else if (vid_grant && streak_q != BURST_MAX)
            streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            own_cpu_q   <= 1'b0;
            rd_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            vid_ack_q   <= 1'b0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            own_cpu_q   <= own_cpu_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_done_q  <= cpu_done_d;
            vid_ack_q   <= vid_ack_d;
            streak_q    <= streak_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign vid_ack   = vid_ack_q;
    assign vid_rdata = vid_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a synchronous RAM model.
module tb_mem_arbiter;

`ifdef ROM_PROTECT_EN
    localparam bit ROM_ON = 1'b1;
`else
    localparam bit ROM_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        cpu_done;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic [7:0]  mem_q;

    always #5 clock = ~clock;

    mem_arbiter #(.VID_BURST(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_ack   (vid_ack),
        .vid_rdata (vid_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q)
    );

    // RAM model with a preload port so only one process writes the array.
    logic [7:0]  ram [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clock) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (mem_wren)
            ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
        int          wren_n;
        int          hold;
    } vec_t;

    vec_t        tbl [7];
    logic [7:0]  sb_cpu [$];
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          ack_cnt = 0;
    int          wren_cnt = 0;
    logic [15:0] wren_addr = '0;
    logic [7:0]  vid_exp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample DUT outputs on the falling edge and retire scoreboard entries.
    task automatic cyc();
        logic [7:0] e;
        @(negedge clock);
        if (mem_wren) begin
            wren_cnt++;
            wren_addr = mem_addr;
        end
        if (cpu_done) begin
            done_cnt++;
            chk("cpu_done_expected", sb_cpu.size() > 0, 1'b1);
            if (sb_cpu.size() > 0) begin
                e = sb_cpu.pop_front();
                chk("cpu_rdata", cpu_rdata, e);
            end
        end
        if (vid_ack) begin
            ack_cnt++;
            chk("vid_rdata", vid_rdata, vid_exp);
        end
    endtask

    task automatic do_cpu(input vec_t v);
        int d0, w0, n;
        d0 = done_cnt;
        w0 = wren_cnt;
        cpu_rd    = v.rd;
        cpu_wr    = v.wr;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        sb_cpu.push_back(v.exp);
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            cyc();
            n++;
        end
        chk("cpu_latency", n, 3);
        repeat (v.hold) cyc();
        chk("cpu_done_count", done_cnt - d0, 1);
        chk("wren_cycles", wren_cnt - w0, v.wren_n);
        if (v.wren_n > 0)
            chk("wren_addr", wren_addr, v.addr);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_addr"},  mem_addr,  0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wren"},  mem_wren,  0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_vid_rdata"}, vid_rdata, 0);
        chk({tag, "_cpu_done"},  cpu_done,  0);
        chk({tag, "_vid_ack"},   vid_ack,   0);
    endtask

    initial begin
        int d0, a0, n, ack_at, done_at;
        logic [15:0] pre_a [6];
        logic [7:0]  pre_d [6];
        vec_t v;

        reset = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        pre_a = '{16'h8000, 16'h8001, 16'h1234, 16'hFFFF, 16'h0100, 16'h2000};
        pre_d = '{8'hA5,    8'h5A,    8'h77,    8'hC3,    8'hEE,    8'h11};
        for (int i = 0; i < 6; i++) begin
            pl_en = 1'b1; pl_addr = pre_a[i]; pl_data = pre_d[i];
            cyc();
        end
        pl_en = 1'b0;
        cyc();
        check_zero("reset");

        // Strobe already high when reset releases: no access may follow.
        cpu_rd = 1'b1; cpu_addr = 16'h8000;
        cyc();
        reset = 1'b0;
        repeat (10) cyc();
        chk("held_strobe_no_done", done_cnt, 0);
        chk("held_strobe_no_addr", mem_addr, 0);
        cpu_rd = 1'b0;
        repeat (2) cyc();

        tbl[0] = '{1'b1, 1'b0, 16'h8000, 8'h00, 8'hA5, 0, 25};
        tbl[1] = '{1'b1, 1'b0, 16'h8001, 8'h00, 8'h5A, 0, 3};
        tbl[2] = '{1'b0, 1'b1, 16'h4000, 8'h3C, 8'h5A, 1, 3};
        tbl[3] = '{1'b1, 1'b0, 16'h4000, 8'h00, 8'h3C, 0, 3};
        tbl[4] = '{1'b1, 1'b1, 16'h1234, 8'h99, 8'h77, 0, 3};
        tbl[5] = '{1'b0, 1'b1, 16'h0100, 8'h55, 8'h77, ROM_ON ? 0 : 1, 3};
        tbl[6] = '{1'b1, 1'b0, 16'h0100, 8'h00, ROM_ON ? 8'hEE : 8'h55, 0, 3};
        for (int i = 0; i < 7; i++)
            do_cpu(tbl[i]);
        chk("ram_0100", ram[16'h0100], ROM_ON ? 8'hEE : 8'h55);
        chk("ram_1234", ram[16'h1234], 8'h77);

        // Simultaneous requests with no streak: video first, CPU 3 cycles later.
        d0 = done_cnt; a0 = ack_cnt;
        vid_addr = 16'h2000; vid_exp = 8'h11; vid_req = 1'b1;
        cpu_rd = 1'b1; cpu_addr = 16'hFFFF;
        sb_cpu.push_back(8'hC3);
        ack_at = -1; done_at = -1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c == 1) vid_req = 1'b0;
            if (ack_at < 0 && ack_cnt != a0) ack_at = c;
            if (done_at < 0 && done_cnt != d0) done_at = c;
        end
        chk("simul_ack_cycle", ack_at, 3);
        chk("simul_done_cycle", done_at, 6);
        chk("simul_ack_count", ack_cnt - a0, 1);
        cpu_rd = 1'b0;
        repeat (2) cyc();

        // Continuous video stream, CPU edge: 3 video acks, then the CPU.
        a0 = ack_cnt;
        vid_req = 1'b1;
        n = 0;
        while (ack_cnt == a0 && n < 10) begin
            cyc();
            n++;
        end
        chk("stream_first_ack", ack_cnt - a0, 1);
        a0 = ack_cnt; d0 = done_cnt;
        cpu_rd = 1'b1; cpu_addr = 16'h8001;
        sb_cpu.push_back(8'h5A);
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            cyc();
            n++;
        end
        vid_req = 1'b0;
        cpu_rd = 1'b0;
        chk("conflict_vid_acks", ack_cnt - a0, 3);
        chk("conflict_done_within_12", n <= 12, 1'b1);
        repeat (4) cyc();

        // Reset while in ISSUE: access abandoned, outputs cleared.
        d0 = done_cnt; a0 = ack_cnt;
        cpu_rd = 1'b1; cpu_addr = 16'h8000;
        cyc();
        reset = 1'b1;
        cyc();
        check_zero("midrst");
        cpu_rd = 1'b0;
        cyc();
        reset = 1'b0;
        repeat (4) cyc();
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_ack", ack_cnt - a0, 0);
        v = '{1'b1, 1'b0, 16'h8001, 8'h00, 8'h5A, 0, 3};
        do_cpu(v);

        chk("scoreboard_empty", sb_cpu.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
